load_store_unit: RTL and testbench

- Data-memory access unit sitting in the execute stage, directly upstream of retire.
- Takes a decoded load/store (operation, effective address, store data), runs a req/gnt/rvalid handshake on the data bus and stalls the pipeline until the access completes.
- Hands the raw 32-bit read word to retire; retire does byte/half extraction and sign extension from address bits [1:0].
- Flags misaligned accesses and bus errors without touching memory.

---
 rtl/load_store_unit_pkg.sv | 26 ++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: instruction operations, atomic
// extension selector, LSU states and the access-size alignment helper.
package load_store_unit_pkg;

    typedef enum logic [4:0] {
        NOP, ADD, SUB, XOR, SLT, BEQ, JAL, CSRRW,
        LB, LBU, LH, LHU, LW, SB, SH, SW, LR_W, SC_W
    } iType_e;

    typedef enum logic [1:0] {AMO_OFF, AMO_A, AMO_ZALRSC, AMO_ZAAMO} atomic_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_H:  return offset[0];
            SIZE_W:  return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Execute-stage data-memory access unit: one outstanding req/gnt/rvalid access,
// pipeline stall until completion, raw read word handed to retire.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter atomic_e AMOEXT = AMO_A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  iType_e      operation_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] mem_data_o,
    output logic        misaligned_o,
    output logic        access_fault_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam logic LRSC_EN = (AMOEXT == AMO_A) || (AMOEXT == AMO_ZALRSC);

    lsu_state_e  state_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  we_r;
    logic        load_r;

    logic        is_mem_s;
    logic        is_load_s;
    logic [1:0]  size_s;
    logic        misaligned_s;
    logic        start_s;
    logic [3:0]  we_s;
    logic [31:0] wdata_s;

    // Decode the operation into memory access kind and size.
    always_comb begin
        is_mem_s  = 1'b0;
        is_load_s = 1'b0;
        size_s    = SIZE_B;
        case (operation_i)
            LB, LBU: begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SIZE_B; end
            LH, LHU: begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SIZE_H; end
            LW:      begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SIZE_W; end
            SB:      begin is_mem_s = 1'b1; size_s = SIZE_B; end
            SH:      begin is_mem_s = 1'b1; size_s = SIZE_H; end
            SW:      begin is_mem_s = 1'b1; size_s = SIZE_W; end
            LR_W:    begin is_mem_s = LRSC_EN; is_load_s = 1'b1; size_s = SIZE_W; end
            SC_W:    begin is_mem_s = LRSC_EN; size_s = SIZE_W; end
            default: begin is_mem_s = 1'b0; end
        endcase
    end

    assign misaligned_s = addr_misaligned(size_s, addr_i[1:0]);
    assign start_s      = (state_r == IDLE) && valid_i && is_mem_s && !misaligned_s;
    assign misaligned_o = (state_r == IDLE) && valid_i && is_mem_s && misaligned_s;

    // Byte-lane enables and store data replicated across the lanes.
    always_comb begin
        we_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        if (!is_load_s) begin
            case (size_s)
                SIZE_B: begin
                    we_s    = 4'b0001 << addr_i[1:0];
                    wdata_s = {4{wdata_i[7:0]}};
                end
                SIZE_H: begin
                    we_s    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{wdata_i[15:0]}};
                end
                default: begin
                    we_s    = 4'b1111;
                    wdata_s = wdata_i;
                end
            endcase
        end else begin
            we_s    = 4'b0000;
            wdata_s = 32'h0000_0000;
        end
    end

    // Bus request and pipeline handshake; the first request cycle bypasses the latches.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_addr_o     = 32'h0000_0000;
        mem_we_o       = 4'b0000;
        mem_wdata_o    = 32'h0000_0000;
        stall_o        = 1'b0;
        done_o         = 1'b0;
        access_fault_o = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    mem_req_o   = 1'b1;
                    mem_addr_o  = {addr_i[31:2], 2'b00};
                    mem_we_o    = we_s;
                    mem_wdata_o = wdata_s;
                    stall_o     = 1'b1;
                end else begin
                    mem_req_o = 1'b0;
                end
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = addr_r;
                mem_we_o    = we_r;
                mem_wdata_o = wdata_r;
                stall_o     = 1'b1;
            end
            WAIT_RESP: begin
                if (mem_rvalid_i) begin
                    done_o         = 1'b1;
                    access_fault_o = mem_err_i;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Access sequencing, request latches and the read-data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            we_r       <= 4'b0000;
            load_r     <= 1'b0;
            mem_data_o <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        addr_r  <= {addr_i[31:2], 2'b00};
                        wdata_r <= wdata_s;
                        we_r    <= we_s;
                        load_r  <= is_load_s;
                        state_r <= mem_gnt_i ? WAIT_RESP : REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state_r <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        if (load_r && !mem_err_i) begin
                            mem_data_o <= mem_rdata_i;
                        end
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        valid_i;
    iType_e      operation_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] mem_data_o;
    logic        misaligned_o;
    logic        access_fault_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_data;

    iType_e ops [18] = '{NOP, ADD, SUB, XOR, SLT, BEQ, JAL, CSRRW,
                         LB, LBU, LH, LHU, LW, SB, SH, SW, LR_W, SC_W};

    load_store_unit #(.AMOEXT(AMO_A)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .operation_i(operation_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
        .mem_data_o(mem_data_o), .misaligned_o(misaligned_o), .access_fault_o(access_fault_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        valid_i      = 1'b0;
        mem_gnt_i    = 1'($urandom_range(0, 1));
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_err_i    = 1'($urandom_range(0, 1));
        mem_rdata_i  = $urandom;
        @(negedge clk);
        check_eq("idle_stall", 32'(stall_o), 32'd0);
        check_eq("idle_req", 32'(mem_req_o), 32'd0);
        check_eq("idle_done", 32'(done_o), 32'd0);
        check_eq("idle_fault", 32'(access_fault_o), 32'd0);
        next_cycle();
        check_eq("idle_data", mem_data_o, exp_data);
    endtask

    // Model: an operation is a memory access of nbytes bytes at addr; stores enable
    // the bytes it covers and each lane carries byte (lane mod nbytes) of the store data.
    task automatic run_txn(input iType_e op, input logic [31:0] addr, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic err, input logic [31:0] rd);
        logic        is_mem;
        logic        is_load;
        logic        misal;
        int          nbytes;
        int          lane;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        is_mem  = 1'b1;
        is_load = 1'b0;
        nbytes  = 4;
        case (op)
            LB, LBU:  begin is_load = 1'b1; nbytes = 1; end
            LH, LHU:  begin is_load = 1'b1; nbytes = 2; end
            LW, LR_W: begin is_load = 1'b1; nbytes = 4; end
            SB:       nbytes = 1;
            SH:       nbytes = 2;
            SW, SC_W: nbytes = 4;
            default:  is_mem = 1'b0;
        endcase
        lane  = int'(addr % 4);
        misal = is_mem && ((addr % nbytes) != 0);
        for (int j = 0; j < 4; j++) begin
            exp_we[j]        = !is_load && (j >= lane) && (j < lane + nbytes);
            exp_wd[8*j +: 8] = wd[8*(j % nbytes) +: 8];
        end

        valid_i      = 1'b1;
        operation_i  = op;
        addr_i       = addr;
        wdata_i      = wd;
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_err_i    = 1'($urandom_range(0, 1));
        mem_rdata_i  = $urandom;

        if (!is_mem || misal) begin
            mem_gnt_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("pass_misaligned", 32'(misaligned_o), 32'(misal));
            check_eq("pass_stall", 32'(stall_o), 32'd0);
            check_eq("pass_req", 32'(mem_req_o), 32'd0);
            check_eq("pass_done", 32'(done_o), 32'd0);
            next_cycle();
            valid_i = 1'b0;
            check_eq("pass_data", mem_data_o, exp_data);
            return;
        end

        for (int c = 0; c <= gdly; c++) begin
            if (c > 0) begin
                valid_i      = 1'($urandom_range(0, 1));
                operation_i  = ops[$urandom_range(0, 17)];
                addr_i       = $urandom;
                wdata_i      = $urandom;
                mem_rvalid_i = 1'($urandom_range(0, 1));
                mem_err_i    = 1'($urandom_range(0, 1));
                mem_rdata_i  = $urandom;
            end
            mem_gnt_i = (c == gdly);
            @(negedge clk);
            check_eq("req_valid", 32'(mem_req_o), 32'd1);
            check_eq("req_addr", mem_addr_o, {addr[31:2], 2'b00});
            check_eq("req_we", 32'(mem_we_o), 32'(exp_we));
            if (!is_load) check_eq("req_wdata", mem_wdata_o, exp_wd);
            check_eq("req_stall", 32'(stall_o), 32'd1);
            check_eq("req_done", 32'(done_o), 32'd0);
            check_eq("req_misaligned", 32'(misaligned_o), 32'd0);
            next_cycle();
        end

        for (int c = 0; c <= rdly; c++) begin
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (c == rdly);
            mem_err_i    = (c == rdly) ? err : 1'($urandom_range(0, 1));
            mem_rdata_i  = (c == rdly) ? rd : $urandom;
            @(negedge clk);
            check_eq("resp_req", 32'(mem_req_o), 32'd0);
            check_eq("resp_stall", 32'(stall_o), 32'(c != rdly));
            check_eq("resp_done", 32'(done_o), 32'(c == rdly));
            check_eq("resp_fault", 32'(access_fault_o), 32'((c == rdly) && err));
            next_cycle();
        end
        valid_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        if (is_load && !err) exp_data = rd;
        check_eq("resp_data", mem_data_o, exp_data);
    endtask

    task automatic reset_mid_access();
        valid_i     = 1'b1;
        operation_i = LW;
        addr_i      = 32'h0000_0080;
        mem_gnt_i   = 1'b1;
        next_cycle();
        valid_i   = 1'b0;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_stall", 32'(stall_o), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_data", mem_data_o, 32'd0);
        exp_data = 32'd0;
        next_cycle();
        reset_n      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("rst_late_done", 32'(done_o), 32'd0);
        check_eq("rst_late_stall", 32'(stall_o), 32'd0);
        next_cycle();
        mem_rvalid_i = 1'b0;
        check_eq("rst_late_data", mem_data_o, exp_data);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        exp_data     = 32'd0;
        clk          = 1'b0;
        reset_n      = 1'b0;
        valid_i      = 1'b0;
        operation_i  = NOP;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        mem_err_i    = 1'b0;
        #1;
        check_eq("reset_stall", 32'(stall_o), 32'd0);
        check_eq("reset_req", 32'(mem_req_o), 32'd0);
        check_eq("reset_done", 32'(done_o), 32'd0);
        check_eq("reset_data", mem_data_o, 32'd0);
        check_eq("reset_fault", 32'(access_fault_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        run_txn(LW, 32'h0000_0100, 32'd0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        run_txn(SB, 32'h0000_0203, 32'h0000_00A5, 3, 0, 1'b0, 32'h1111_1111);
        run_txn(SH, 32'h0000_0101, 32'h0000_1234, 0, 0, 1'b0, 32'd0);
        run_txn(LW, 32'h0000_0102, 32'd0, 0, 0, 1'b0, 32'd0);
        run_txn(LH, 32'h0000_0040, 32'd0, 0, 1, 1'b1, 32'h5555_5555);
        reset_mid_access();
        run_txn(LW, 32'h0000_0010, 32'd0, 0, 0, 1'b0, 32'h0BAD_F00D);
        run_txn(SW, 32'h0000_0014, 32'h1234_5678, 0, 0, 1'b0, 32'd0);
        run_txn(SH, 32'h0000_0022, 32'h0000_BEEF, 1, 2, 1'b0, 32'd0);
        run_txn(LR_W, 32'h0000_0030, 32'd0, 0, 0, 1'b0, 32'h7777_0001);
        run_txn(SC_W, 32'h0000_0030, 32'h8888_0002, 0, 0, 1'b0, 32'd0);
        idle_cycle();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_txn(ops[$urandom_range(0, 17)], a, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
